// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: word width, opcode values, the register-none
// marker and small helpers for instruction length and constant extraction.
package y86_pkg;

    localparam int WORD = 64;

    // Instruction codes (upper nibble of the first instruction byte)
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Register id meaning "no register"
    localparam logic [3:0] RNONE = 4'hF;

    // Encoded length in bytes of a valid instruction; undefined codes report 1
    // so the caller can step past a bad byte.
    function automatic logic [3:0] instr_len(input logic [3:0] icode);
        case (icode)
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: instr_len = 4'd2;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:     instr_len = 4'd10;
            I_JXX, I_CALL:                    instr_len = 4'd9;
            default:                          instr_len = 4'd1;
        endcase
    endfunction

    // Eight bytes in fetch order (first byte in [63:56]) read as a
    // little-endian word.
    function automatic logic [WORD-1:0] le_word(input logic [63:0] bytes_in);
        logic [WORD-1:0] w;
        for (int i = 0; i < 8; i++) begin
            w[8*i +: 8] = bytes_in[63-8*i -: 8];
        end
        return w;
    endfunction

endpackage

// File: rtl/y86_fetch_decode.sv
// Combinational fetch stage: splits the 10-byte instruction window into its
// fields, computes the fall-through address and flags bad opcodes / bad PC.
module y86_fetch_decode
    import y86_pkg::*;
#(
    parameter int unsigned IMEM_SIZE = 1024
) (
    input  logic [WORD-1:0] PC,
    input  logic [79:0]     instruct,
    output logic [3:0]      icode,
    output logic [3:0]      ifun,
    output logic [3:0]      ra,
    output logic [3:0]      rb,
    output logic [WORD-1:0] valC,
    output logic [WORD-1:0] valP,
    output logic            mem_err,
    output logic            instruct_err
);

    // Field split, constant extraction and opcode validation
    always_comb begin
        // NOTE: every output gets a default before the case statements so no
        // path leaves a variable unassigned and no latch is inferred.
        icode        = instruct[79:76];
        ifun         = instruct[75:72];
        ra           = RNONE;
        rb           = RNONE;
        valC         = '0;
        instruct_err = 1'b0;

        // Only forms carrying a register byte look at instruct[71:64], so
        // unused window bytes never leak into ra/rb for short instructions.
        case (icode)
            I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
                ra = instruct[71:68];
                rb = instruct[67:64];
            end
            default: ;
        endcase

        case (icode)
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: valC = le_word(instruct[63:0]);
            I_JXX, I_CALL:                valC = le_word(instruct[71:8]);
            default: ;
        endcase

        case (icode)
            I_HALT, I_NOP, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_CALL, I_RET, I_PUSHQ, I_POPQ: instruct_err = (ifun != 4'h0);
            I_RRMOVQ, I_JXX:                instruct_err = (ifun > 4'h6);
            I_OPQ:                          instruct_err = (ifun > 4'h3);
            default:                        instruct_err = 1'b1;
        endcase
    end

    // Fall-through address; a bad opcode advances by a single byte
    always_comb begin
        valP = PC + (instruct_err ? WORD'(1) : WORD'(instr_len(icode)));
    end

    // Instruction-memory range check, independent of opcode validity
    always_comb begin
        mem_err = (PC >= WORD'(IMEM_SIZE));
    end

endmodule

// File: rtl/y86_fetch_pc_unit.sv
// SEQ front end: combinational fetch/decode plus the registered PC-update
// stage that selects the next program counter.
module y86_fetch_pc_unit
    import y86_pkg::*;
#(
    parameter int unsigned IMEM_SIZE = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WORD-1:0] PC,
    input  logic [79:0]     instruct,
    input  logic            cond,
    input  logic [WORD-1:0] valM,
    output logic [3:0]      icode,
    output logic [3:0]      ifun,
    output logic [3:0]      ra,
    output logic [3:0]      rb,
    output logic [WORD-1:0] valC,
    output logic [WORD-1:0] valP,
    output logic            mem_err,
    output logic            instruct_err,
    output logic [WORD-1:0] next_pc
);

    logic [WORD-1:0] pc_sel;

    y86_fetch_decode #(
        .IMEM_SIZE(IMEM_SIZE)
    ) u_fetch_decode (
        .PC          (PC),
        .instruct    (instruct),
        .icode       (icode),
        .ifun        (ifun),
        .ra          (ra),
        .rb          (rb),
        .valC        (valC),
        .valP        (valP),
        .mem_err     (mem_err),
        .instruct_err(instruct_err)
    );

    // Next-PC select: faults and halt freeze the PC, then control transfers
    always_comb begin
        pc_sel = valP;
        if (mem_err || instruct_err || icode == I_HALT) begin
            pc_sel = PC;
        end else if (icode == I_CALL) begin
            pc_sel = valC;
        end else if (icode == I_JXX) begin
            pc_sel = cond ? valC : valP;
        end else if (icode == I_RET) begin
            pc_sel = valM;
        end
    end

    // PC register; reset is asynchronous and overrides a coincident edge
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge values, independent of process ordering.
        if (rst) begin
            next_pc <= '0;
        end else begin
            next_pc <= pc_sel;
        end
    end

endmodule

// File: tb/tb_y86_fetch_pc_unit.sv
// Self-checking bench for y86_fetch_pc_unit: hand-written vectors from the
// instruction set rules, an asynchronous reset sequence, and randomized
// vectors compared against a byte-level reference model.
module tb_y86_fetch_pc_unit;

    logic        clk;
    logic        rst;
    logic [63:0] PC;
    logic [79:0] instruct;
    logic        cond;
    logic [63:0] valM;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valC, valP, next_pc;
    logic        mem_err, instruct_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [63:0] pc;
        logic [79:0] instr;
        logic        cnd;
        logic [63:0] valm;
        logic [3:0]  e_icode, e_ifun, e_ra, e_rb;
        logic [63:0] e_valc, e_valp;
        logic        e_ierr, e_merr;
        logic [63:0] e_npc;
    } vec_t;

    y86_fetch_pc_unit #(.IMEM_SIZE(1024)) dut (
        .clk         (clk),
        .rst         (rst),
        .PC          (PC),
        .instruct    (instruct),
        .cond        (cond),
        .valM        (valM),
        .icode       (icode),
        .ifun        (ifun),
        .ra          (ra),
        .rb          (rb),
        .valC        (valC),
        .valP        (valP),
        .mem_err     (mem_err),
        .instruct_err(instruct_err),
        .next_pc     (next_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: treats the window as ten bytes and applies the ISA
    // tables directly (length, max ifun, constant offset).
    function automatic vec_t ref_model(input logic [63:0] pc, input logic [79:0] instr,
                                       input logic cnd, input logic [63:0] valm);
        vec_t v;
        logic [7:0] b [10];
        int len_tbl  [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
        int max_ifun [16] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0, -1, -1, -1, -1};
        int ic, fn, off;
        for (int i = 0; i < 10; i++) b[i] = instr[79-8*i -: 8];
        ic = int'(b[0][7:4]);
        fn = int'(b[0][3:0]);
        v.pc = pc; v.instr = instr; v.cnd = cnd; v.valm = valm;
        v.e_icode = b[0][7:4];
        v.e_ifun  = b[0][3:0];
        if (ic inside {2, 3, 4, 5, 6, 10, 11}) begin
            v.e_ra = b[1][7:4];
            v.e_rb = b[1][3:0];
        end else begin
            v.e_ra = 4'hF;
            v.e_rb = 4'hF;
        end
        off = (ic inside {3, 4, 5}) ? 2 : (ic inside {7, 8}) ? 1 : 0;
        v.e_valc = 64'd0;
        if (off != 0)
            for (int k = 0; k < 8; k++) v.e_valc = v.e_valc | (64'(b[off+k]) << (8 * k));
        v.e_ierr = (ic > 11) || (fn > max_ifun[ic]);
        v.e_merr = (pc >= 64'd1024);
        v.e_valp = pc + (v.e_ierr ? 64'd1 : 64'(len_tbl[ic]));
        if (v.e_merr || v.e_ierr || ic == 0) v.e_npc = pc;
        else if (ic == 8)                    v.e_npc = v.e_valc;
        else if (ic == 7)                    v.e_npc = cnd ? v.e_valc : v.e_valp;
        else if (ic == 9)                    v.e_npc = valm;
        else                                 v.e_npc = v.e_valp;
        return v;
    endfunction

    // Drive one vector away from the edge, check fetch outputs, then the
    // registered next_pc just after the following rising edge.
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        PC = v.pc; instruct = v.instr; cond = v.cnd; valM = v.valm;
        #1;
        check({tag, ".icode"},        64'(icode),        64'(v.e_icode));
        check({tag, ".ifun"},         64'(ifun),         64'(v.e_ifun));
        check({tag, ".ra"},           64'(ra),           64'(v.e_ra));
        check({tag, ".rb"},           64'(rb),           64'(v.e_rb));
        check({tag, ".valC"},         valC,              v.e_valc);
        check({tag, ".valP"},         valP,              v.e_valp);
        check({tag, ".instruct_err"}, 64'(instruct_err), 64'(v.e_ierr));
        check({tag, ".mem_err"},      64'(mem_err),      64'(v.e_merr));
        @(posedge clk);
        #1;
        check({tag, ".next_pc"},      next_pc,           v.e_npc);
    endtask

    vec_t tbl [14];

    initial begin
        // Hand-derived vectors; X bytes mark window positions the instruction must ignore
        //          pc                     instr                                  cnd valm     ic    fn    ra    rb    valC                   valP                   ierr merr next_pc
        tbl[0]  = '{64'd62,   {8'h61, 8'h23, 64'hx},                 1'b0, 64'd0,   4'h6, 4'h1, 4'h2, 4'h3, 64'd0,                 64'd64,                1'b0, 1'b0, 64'd64};
        tbl[1]  = '{64'd64,   {8'h20, 8'h34, 64'hx},                 1'b0, 64'd0,   4'h2, 4'h0, 4'h3, 4'h4, 64'd0,                 64'd66,                1'b0, 1'b0, 64'd66};
        tbl[2]  = '{64'd60,   {8'h70, 8'h34, 56'h0, 8'hx},           1'b1, 64'd0,   4'h7, 4'h0, 4'hF, 4'hF, 64'h34,                64'd69,                1'b0, 1'b0, 64'h34};
        tbl[3]  = '{64'd60,   {8'h70, 8'h34, 56'h0, 8'hx},           1'b0, 64'd0,   4'h7, 4'h0, 4'hF, 4'hF, 64'h34,                64'd69,                1'b0, 1'b0, 64'd69};
        tbl[4]  = '{64'h100,  {8'h30, 8'hF2, 64'h0807060504030201},  1'b0, 64'd0,   4'h3, 4'h0, 4'hF, 4'h2, 64'h0102030405060708,  64'h10A,               1'b0, 1'b0, 64'h10A};
        tbl[5]  = '{64'd68,   {8'h00, 72'hx},                        1'b0, 64'd0,   4'h0, 4'h0, 4'hF, 4'hF, 64'd0,                 64'd69,                1'b0, 1'b0, 64'd68};
        tbl[6]  = '{64'd100,  {8'h80, 8'h00, 8'h02, 48'h0, 8'hx},    1'b0, 64'd0,   4'h8, 4'h0, 4'hF, 4'hF, 64'h200,               64'd109,               1'b0, 1'b0, 64'h200};
        tbl[7]  = '{64'd200,  {8'h90, 72'hx},                        1'b0, 64'h123, 4'h9, 4'h0, 4'hF, 4'hF, 64'd0,                 64'd201,               1'b0, 1'b0, 64'h123};
        tbl[8]  = '{64'd10,   {8'hC0, 72'hx},                        1'b0, 64'd0,   4'hC, 4'h0, 4'hF, 4'hF, 64'd0,                 64'd11,                1'b1, 1'b0, 64'd10};
        tbl[9]  = '{64'd20,   {8'h65, 8'h12, 64'hx},                 1'b0, 64'd0,   4'h6, 4'h5, 4'h1, 4'h2, 64'd0,                 64'd21,                1'b1, 1'b0, 64'd20};
        tbl[10] = '{64'd1024, {8'h10, 72'hx},                        1'b0, 64'd0,   4'h1, 4'h0, 4'hF, 4'hF, 64'd0,                 64'd1025,              1'b0, 1'b1, 64'd1024};
        tbl[11] = '{64'hFFFF_FFFF_FFFF_FFFC, {8'h30, 8'hF0, 64'h1},  1'b0, 64'd0,   4'h3, 4'h0, 4'hF, 4'h0, 64'h0100_0000_0000_0000, 64'd6,               1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC};
        tbl[12] = '{64'd2000, {8'hB1, 8'h5F, 64'hx},                 1'b0, 64'd0,   4'hB, 4'h1, 4'h5, 4'hF, 64'd0,                 64'd2001,              1'b1, 1'b1, 64'd2000};
        tbl[13] = '{64'd30,   {8'h27, 8'h01, 64'hx},                 1'b1, 64'd0,   4'h2, 4'h7, 4'h0, 4'h1, 64'd0,                 64'd31,                1'b1, 1'b0, 64'd30};

        rst = 1'b1; PC = '0; instruct = '0; cond = 1'b0; valM = '0;
        #12;
        check("reset.next_pc", next_pc, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_release.next_pc", next_pc, 64'd0);

        for (int i = 0; i < 14; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Asynchronous reset mid-run: clears without an edge, holds through edges
        run_vec(tbl[0], "pre_rst");
        #2;
        rst = 1'b1;
        #1;
        check("async_rst.next_pc", next_pc, 64'd0);
        @(posedge clk);
        #1;
        check("rst_held.next_pc", next_pc, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_released.next_pc", next_pc, 64'd0);
        @(posedge clk);
        #1;
        check("post_rst_edge.next_pc", next_pc, 64'd64);

        // Randomized vectors against the reference model
        for (int n = 0; n < 300; n++) begin
            logic [63:0] r_pc;
            logic [79:0] r_in;
            logic [7:0]  op;
            r_pc = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom}
                                               : 64'($urandom_range(0, 1100));
            r_in = 80'({$urandom, $urandom, $urandom});
            op[7:4] = 4'($urandom_range(0, 15));
            op[3:0] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15))
                                                  : 4'($urandom_range(0, 3));
            r_in[79:72] = op;
            run_vec(ref_model(r_pc, r_in, 1'($urandom), {$urandom, $urandom}),
                    $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/y86_fetch_pc_unit.md
Name: y86_fetch_pc_unit

Overview:
Sequential Y86-64 front end: fetch/decode of one instruction window plus the PC-update stage.
- Combinationally splits a 10-byte instruction window (fetched at PC) into icode, ifun, rA, rB, valC and valP.
- Flags instruction and memory-range errors.
- Registers next_pc on the rising clock edge.
- Sits between instruction memory and the decode/execute stages of the SEQ processor.

Parameters:
IMEM_SIZE, 1024, instruction memory size in bytes; PC values at or beyond this raise mem_err.

Ports:
clk  in  1  system clock; next_pc updates on rising edge
rst  in  1  reset, asynchronous, active-high
PC  in  64  current program counter (byte address)
instruct  in  80  instruction bytes at PC..PC+9; [79:72]=byte PC, [7:0]=byte PC+9
cond  in  1  branch condition from execute (used by jXX)
valM  in  64  return address read from stack (used by ret)
icode  out  4  instruct[79:76]
ifun  out  4  instruct[75:72]
ra  out  4  register A field
rb  out  4  register B field
valC  out  64  constant/displacement/destination
valP  out  64  address of the sequentially next instruction
mem_err  out  1  PC out of instruction-memory range
instruct_err  out  1  invalid icode/ifun
next_pc  out  64  registered next program counter

Behaviour:
- Reset: asynchronous, active-high. While rst=1, next_pc=0. Fetch outputs are combinational and not affected by rst.
- Fetch is purely combinational from PC and instruct, with zero latency.
- Opcode fields: icode=instruct[79:76], ifun=instruct[75:72].
- Register byte (instruct[71:64]) exists for icode 2,3,4,5,6,A,B: ra=instruct[71:68], rb=instruct[67:64].
- Instructions without a register byte drive ra=rb=4'hF.
- valC, for icode 3/4/5: bytes PC+2..PC+9 read little-endian, i.e. valC = {instruct[7:0], instruct[15:8], …, instruct[63:56]}.
- valC, for icode 7/8: bytes PC+1..PC+8 read little-endian.
- valC, all other icodes: 0.
- Lengths and valP = PC + length (64-bit wrap-around):
  - halt(0)=1, nop(1)=1, ret(9)=1
  - cmovXX(2)=2, OPq(6)=2, pushq(A)=2, popq(B)=2
  - irmovq(3)=10, rmmovq(4)=10, mrmovq(5)=10
  - jXX(7)=9, call(8)=9
- instruct_err=1 in any of these cases; when set, valP=PC+1:
  - icode > B
  - ifun≠0 for icode 0,1,3,4,5,8,9,A,B
  - ifun>6 for icode 2/7
  - ifun>3 for icode 6
- mem_err=1 when PC ≥ IMEM_SIZE. This is independent of instruct_err; both may assert together.
- next_pc register, on rising clk when rst=0, in priority order:
  1. mem_err or instruct_err or icode=0 (halt): next_pc <= PC (hold)
  2. icode=8 (call): next_pc <= valC
  3. icode=7 (jXX): next_pc <= cond ? valC : valP. Unconditional jmp (ifun=0) still obeys cond; execute supplies cond=1 for it.
  4. icode=9 (ret): next_pc <= valM
  5. otherwise: next_pc <= valP
- Simultaneous edge and reset: reset wins. next_pc stays 0 until the first rising edge after rst deasserts.
- X/unknown bytes in unused window positions must not affect the outputs of shorter instructions, except valC/valP for those icodes that use the bytes.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants I_HALT…I_POPQ (0..B)
  - RNONE=4'hF
  - instruction-length function
  - WORD=64
- One natural sub-module: y86_fetch_decode (the combinational split/length/error logic).
- The top wrapper adds the next_pc register and select mux.

Test Plan:
1. rst=1 pulsed mid-run with next_pc=0x40 → next_pc=0 immediately (async), no clock needed; holds 0 until the first edge after release.
2. PC=62, instruct=0x6123_XX… (OPq addq) → icode=6 ifun=1 ra=2 rb=3 valC=0 valP=64; after edge next_pc=64; no errors.
3. PC=64, instruct=0x2034… (rrmovq) → icode=2 ifun=0 ra=3 rb=4 valP=66 next_pc=66.
4. PC=60, jXX, instruct bytes 70 34 00 00 00 00 00 00 00 xx → valC=0x34 valP=69; cond=1 → next_pc=0x34; cond=0 → next_pc=69. Also irmovq 30 F2 + bytes 0x0807…01 → valC=0x0102030405060708 valP=PC+10.
5. PC=68, halt (0x00) → icode=0 valP=69, next_pc holds 68. Then call at PC=100 with valC=0x200 → next_pc=0x200; ret with valM=0x123 → next_pc=0x123.
6. icode=0xC at PC=10 → instruct_err=1, next_pc=10. OPq with ifun=5 → instruct_err=1. PC=1024 → mem_err=1, next_pc holds 1024.
